// File: rtl/cube_pkg.sv
// Shared constants, pin-field layout and scan state encoding for the LED cube scanner.
package cube_pkg;

  localparam int N_LAYERS      = 4;
  localparam int N_COLS        = 16;
  localparam int CELL_W        = 64;
  localparam int PIN_W         = 21;
  localparam int LAYER_W       = 2;

  localparam int PIN_COL_LSB   = 0;
  localparam int PIN_LAYER_LSB = 16;
  localparam int PIN_SYNC      = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Counter width able to hold 0 .. max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/cube_frame_buffer.sv
// Shadow/active double buffer with a single-entry Load handshake.
module cube_frame_buffer
  import cube_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CELL_W-1:0] i_cells,
  input  logic              i_load,
  input  logic              i_swap,
  output logic              o_load_ack,
  output logic [CELL_W-1:0] o_active
);

  logic [CELL_W-1:0] r_shadow;
  logic [CELL_W-1:0] r_active;
  logic              r_pending;
  logic              r_load_ack;
  logic              w_accept;
  logic              w_do_swap;

  // Both decisions use the pre-edge pending flag, so a load colliding with a swap is refused.
  assign w_accept  = i_load & ~r_pending;
  assign w_do_swap = i_swap &  r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow   <= '0;
      r_active   <= '0;
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_load_ack <= w_accept;
      if (w_do_swap) r_active <= r_shadow;
      if (w_accept)  r_shadow <= i_cells;
      if (w_accept)       r_pending <= 1'b1;
      else if (w_do_swap) r_pending <= 1'b0;
    end
  end

  assign o_load_ack = r_load_ack;
  assign o_active   = r_active;

endmodule

// File: rtl/cube_scan_ctrl.sv
// 4x4x4 cube scan sequencer: blank/drive per layer, frame-boundary buffer swap, registered pins.
module cube_scan_ctrl
  import cube_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CELL_W-1:0] i_cells,
  input  logic              i_load,
  output logic              o_load_ack,
  input  logic              i_enable,
  output logic [PIN_W-1:0]  o_pins,
  output logic              o_frame_done
);

  localparam int CNT_W = cnt_width(int'(DWELL_CYCLES), int'(BLANK_CYCLES));
  localparam logic [CNT_W-1:0]   DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAYER_LAST = LAYER_W'(N_LAYERS - 1);

  scan_state_e        r_state, w_state_next;
  logic [LAYER_W-1:0] r_layer, w_layer_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [PIN_W-1:0]   r_pins, w_pins_next;
  logic               r_frame_done;
  logic               w_frame_end;
  logic               w_swap;
  logic [CELL_W-1:0]  w_active;

  cube_frame_buffer u_frame_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cells    (i_cells),
    .i_load     (i_load),
    .i_swap     (w_swap),
    .o_load_ack (o_load_ack),
    .o_active   (w_active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_layer      <= '0;
      r_cnt        <= '0;
      r_pins       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_layer      <= w_layer_next;
      r_cnt        <= w_cnt_next;
      r_pins       <= w_pins_next;
      r_frame_done <= w_frame_end;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_layer_next = r_layer;
    w_cnt_next   = r_cnt;
    w_swap       = 1'b0;
    w_frame_end  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_next = ST_BLANK;
          w_layer_next = '0;
          w_cnt_next   = '0;
          w_swap       = 1'b1;
        end
      end
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_next = ST_DRIVE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = r_cnt + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == DWELL_LAST) begin
          w_cnt_next = '0;
          if (r_layer == LAYER_LAST) begin
            w_frame_end  = 1'b1;
            w_layer_next = '0;
            w_state_next = i_enable ? ST_BLANK : ST_IDLE;
            w_swap       = i_enable;
          end else begin
            w_layer_next = r_layer + 1'b1;
            w_state_next = ST_BLANK;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_layer_next = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Pins are precomputed from the next state; a swap never coincides with entering DRIVE,
  // so the current active buffer is already the one to display.
  always_comb begin
    w_pins_next = '0;
    if (w_state_next == ST_DRIVE) begin
      w_pins_next[PIN_COL_LSB +: N_COLS]     = w_active[w_layer_next * N_COLS +: N_COLS];
      w_pins_next[PIN_LAYER_LSB +: N_LAYERS] = {{(N_LAYERS-1){1'b0}}, 1'b1} << w_layer_next;
      w_pins_next[PIN_SYNC]                  = (w_layer_next == '0);
    end
  end

  assign o_pins       = r_pins;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_cube_scan_ctrl.sv
// Self-checking bench for cube_scan_ctrl: directed scenarios plus randomized load/enable/reset traffic.
module tb_cube_scan_ctrl;

  localparam int unsigned DW    = 4;
  localparam int unsigned BL    = 2;
  localparam int          SLOT  = DW + BL;
  localparam int          FRAME = 4 * SLOT;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        load   = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] cells  = '0;
  logic [20:0] pins;
  logic        ack;
  logic        fd;

  always #5 clk = ~clk;

  cube_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cells      (cells),
    .i_load       (load),
    .o_load_ack   (ack),
    .i_enable     (enable),
    .o_pins       (pins),
    .o_frame_done (fd)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: frame position timeline rather than a state machine.
  bit          m_run;
  int          m_pos;
  logic [63:0] m_shadow, m_active;
  bit          m_pend, m_ack, m_fd;

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0;
    m_pend = 0; m_ack = 0; m_fd = 0;
  endtask

  task automatic model_step();
    bit old_p, sw;
    old_p = m_pend;
    sw    = 0;
    m_ack = load && !old_p;
    m_fd  = 0;
    if (!m_run) begin
      if (enable) begin m_run = 1; m_pos = 0; sw = 1; end
    end else if (m_pos == FRAME - 1) begin
      m_fd = 1;
      if (enable) begin m_pos = 0; sw = 1; end
      else m_run = 0;
    end else begin
      m_pos++;
    end
    if (sw && old_p) begin m_active = m_shadow; m_pend = 0; end
    if (load && !old_p) begin m_shadow = cells; m_pend = 1; end
  endtask

  function automatic logic [20:0] exp_pins();
    logic [20:0] p;
    logic [63:0] t;
    int          lay;
    p = '0;
    if (m_run && (m_pos % SLOT) >= BL) begin
      lay       = m_pos / SLOT;
      t         = m_active >> (lay * 16);
      p[15:0]   = t[15:0];
      p[16+lay] = 1'b1;
      p[20]     = (lay == 0);
    end
    return p;
  endfunction

  function automatic bit in_layer_drive(input int lay);
    return m_run && (m_pos / SLOT) == lay && (m_pos % SLOT) >= BL;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check("pins", {43'd0, pins}, {43'd0, exp_pins()});
    check("load_ack", {63'd0, ack}, {63'd0, m_ack});
    check("frame_done", {63'd0, fd}, {63'd0, m_fd});
    check("layer_onehot", {63'd0, ($countones(pins[19:16]) <= 1)}, 64'd1);
  endtask

  // Called from the negedge; asserts reset mid-cycle and checks outputs clear immediately.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_pins"}, {43'd0, pins}, 64'd0);
    check({tag, "_ack"}, {63'd0, ack}, 64'd0);
    check({tag, "_fd"}, {63'd0, fd}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int fd_last, n_fd, k;
    bit acked;

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_pins", {43'd0, pins}, 64'd0);
    check("reset_ack", {63'd0, ack}, 64'd0);
    check("reset_fd", {63'd0, fd}, 64'd0);
    rst_n = 1'b1;

    // Load then enable: blank, layer 0, blank, layer 1.
    load  = 1'b1;
    cells = 64'h000F_00F0_0F00_F000;
    cycle();
    check("first_ack", {63'd0, ack}, 64'd1);
    load   = 1'b0;
    enable = 1'b1;
    repeat (2) begin cycle(); check("first_blank", {43'd0, pins}, 64'd0); end
    repeat (4) begin cycle(); check("layer0_drive", {43'd0, pins}, 64'h11_F000); end
    repeat (2) begin cycle(); check("layer1_blank", {43'd0, pins}, 64'd0); end
    cycle();
    check("layer1_drive", {43'd0, pins}, 64'h02_0F00);

    // Frame_done period under continuous enable.
    fd_last = -1;
    n_fd    = 0;
    repeat (4 * FRAME) begin
      cycle();
      if (fd) begin
        if (fd_last >= 0) check("fd_period", 64'(cyc - fd_last), 64'(FRAME));
        fd_last = cyc;
        n_fd++;
      end
      if (pins[20]) check("sync_layer0", {60'd0, pins[19:16]}, 64'd1);
    end
    check("fd_count", 64'(n_fd), 64'd4);

    // Two loads back to back: the second waits for the next frame boundary swap.
    load  = 1'b1;
    cells = {$urandom, $urandom};
    acked = 0;
    for (k = 0; k < 4 && !acked; k++) begin cycle(); acked = ack; end
    check("load_a_acked", {63'd0, acked}, 64'd1);
    cells = {$urandom, $urandom};
    acked = 0;
    cycle();
    check("load_b_held_off", {63'd0, ack}, 64'd0);
    for (k = 0; k < 2 * FRAME + 4 && !acked; k++) begin cycle(); acked = ack; end
    check("load_b_acked", {63'd0, acked}, 64'd1);
    load = 1'b0;

    // Enable dropped during layer 1: frame completes, then idle.
    for (k = 0; k < 2 * FRAME && !in_layer_drive(1); k++) cycle();
    check("reach_layer1", {63'd0, in_layer_drive(1)}, 64'd1);
    enable = 1'b0;
    n_fd   = 0;
    repeat (FRAME) begin cycle(); if (fd) n_fd++; end
    check("drop_fd_count", 64'(n_fd), 64'd1);
    check("drop_idle_pins", {43'd0, pins}, 64'd0);

    // Reset during layer 2 drive, then an all-zero display restart.
    enable = 1'b1;
    for (k = 0; k < 3 * FRAME && !in_layer_drive(2); k++) cycle();
    check("reach_layer2", {63'd0, in_layer_drive(2)}, 64'd1);
    do_reset("mid_reset");
    repeat (2) begin cycle(); check("restart_blank", {43'd0, pins}, 64'd0); end
    repeat (FRAME) begin
      cycle();
      check("noload_cols", {48'd0, pins[15:0]}, 64'd0);
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (load && ack) load = 1'b0;
      else if (!load && $urandom_range(7) == 0) begin
        load  = 1'b1;
        cells = {$urandom, $urandom};
      end
      enable = ($urandom_range(15) != 0);
      if (i % 700 == 350) do_reset("rand_reset");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
